// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - round-robin write-back arbiter for the register file write port
module rf_wb_arbiter #(
  parameter int REG_WIDTH = 16,
  parameter int REG_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 gen_valid,
  output logic                 gen_ready,
  input  logic [2:0]           gen_reg,
  input  logic [REG_WIDTH-1:0] gen_data,
  input  logic                 lbi_valid,
  output logic                 lbi_ready,
  input  logic [2:0]           lbi_reg,
  input  logic [7:0]           lbi_imm,
  input  logic                 link_valid,
  output logic                 link_ready,
  input  logic [REG_WIDTH-1:0] link_pc,
  input  logic                 wb_stall,
  output logic                 wr_en,
  output logic [2:0]           wr_sel,
  output logic [REG_WIDTH-1:0] wr_data,
  output logic [1:0]           grant_id,
  input  logic [2:0]           rd1_sel,
  input  logic [2:0]           rd2_sel,
  output logic                 rd1_pending,
  output logic                 rd2_pending
);

  // Source encodings double as grant_id values and last-grant pointer values
  localparam logic [1:0] SRC_NONE = 2'b00;
  localparam logic [1:0] SRC_GEN  = 2'b01;
  localparam logic [1:0] SRC_LBI  = 2'b10;
  localparam logic [1:0] SRC_LINK = 2'b11;

  // Link writes always land in the top register (R7)
  localparam logic [2:0] LINK_REG = 3'(REG_DEPTH - 1);

  logic [1:0] last_ptr;
  logic [1:0] gnt;

  // Round-robin search starting just after the most recent winner
  always_comb begin
    gnt = SRC_NONE;
    if (!rst && !wb_stall) begin
      case (last_ptr)
        SRC_GEN: begin
          if (lbi_valid)       gnt = SRC_LBI;
          else if (link_valid) gnt = SRC_LINK;
          else if (gen_valid)  gnt = SRC_GEN;
        end
        SRC_LBI: begin
          if (link_valid)      gnt = SRC_LINK;
          else if (gen_valid)  gnt = SRC_GEN;
          else if (lbi_valid)  gnt = SRC_LBI;
        end
        default: begin
          if (gen_valid)       gnt = SRC_GEN;
          else if (lbi_valid)  gnt = SRC_LBI;
          else if (link_valid) gnt = SRC_LINK;
        end
      endcase
    end
  end

  // One-hot readies straight from the grant decision
  always_comb begin
    gen_ready  = (gnt == SRC_GEN);
    lbi_ready  = (gnt == SRC_LBI);
    link_ready = (gnt == SRC_LINK);
  end

  // Output stage: register the winning write; sel/data hold when idle
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en    <= 1'b0;
      wr_sel   <= 3'd0;
      wr_data  <= '0;
      grant_id <= SRC_NONE;
      last_ptr <= SRC_LINK;
    end else begin
      wr_en    <= (gnt != SRC_NONE);
      grant_id <= gnt;
      if (gnt != SRC_NONE) begin
        last_ptr <= gnt;
      end
      case (gnt)
        SRC_GEN: begin
          wr_sel  <= gen_reg;
          wr_data <= gen_data;
        end
        SRC_LBI: begin
          wr_sel  <= lbi_reg;
          wr_data <= {{(REG_WIDTH-8){lbi_imm[7]}}, lbi_imm};
        end
        SRC_LINK: begin
          wr_sel  <= LINK_REG;
          wr_data <= link_pc + REG_WIDTH'(2);
        end
        default: ;
      endcase
    end
  end

  // Read-after-write hazard flags against the write in the output stage
  always_comb begin
    rd1_pending = wr_en && (wr_sel == rd1_sel);
    rd2_pending = wr_en && (wr_sel == rd2_sel);
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - scoreboard bench for rf_wb_arbiter
module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        gen_valid, lbi_valid, link_valid, wb_stall;
  logic        gen_ready, lbi_ready, link_ready;
  logic [2:0]  gen_reg, lbi_reg, rd1_sel, rd2_sel, wr_sel;
  logic [15:0] gen_data, link_pc, wr_data;
  logic [7:0]  lbi_imm;
  logic        wr_en, rd1_pending, rd2_pending;
  logic [1:0]  grant_id;

  always #5 clk = ~clk;

  rf_wb_arbiter #(.REG_WIDTH(16), .REG_DEPTH(8)) dut (
    .clk(clk), .rst(rst),
    .gen_valid(gen_valid), .gen_ready(gen_ready), .gen_reg(gen_reg), .gen_data(gen_data),
    .lbi_valid(lbi_valid), .lbi_ready(lbi_ready), .lbi_reg(lbi_reg), .lbi_imm(lbi_imm),
    .link_valid(link_valid), .link_ready(link_ready), .link_pc(link_pc),
    .wb_stall(wb_stall),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data), .grant_id(grant_id),
    .rd1_sel(rd1_sel), .rd2_sel(rd2_sel),
    .rd1_pending(rd1_pending), .rd2_pending(rd2_pending)
  );

  typedef struct {
    logic [2:0]  sel;
    logic [15:0] data;
    logic [1:0]  id;
  } wr_t;

  wr_t         sb[$];
  int          total = 0;
  int          bad = 0;
  logic [1:0]  m_ptr = 2'd3;
  logic [2:0]  last_sel = 3'd0;
  logic [15:0] last_data = 16'd0;
  logic [1:0]  g_dummy;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Next source (1 gen, 2 lbi, 3 link) after p that has valid set; v = {gen,lbi,link}
  function automatic logic [1:0] model_grant(input logic [1:0] p, input logic [2:0] v);
    logic [1:0] c;
    c = p;
    for (int k = 0; k < 3; k++) begin
      c = (c == 2'd3 || c == 2'd0) ? 2'd1 : c + 2'd1;
      if (v[3 - c]) return c;
    end
    return 2'd0;
  endfunction

  // One clock: check readies against the model, push expected write, check output stage
  task automatic step(input logic [2:0] want, input bit use_want, output logic [1:0] g);
    logic [2:0] rdy, vld;
    logic       was_rst;
    logic       exp_en;
    wr_t        r;
    #1;
    rdy = {gen_ready, lbi_ready, link_ready};
    vld = {gen_valid, lbi_valid, link_valid};
    was_rst = rst;
    g = 2'd0;
    if (!rst && !wb_stall) g = model_grant(m_ptr, vld);
    check_eq("ready_onehot", rdy, (g == 2'd0) ? 3'b000 : (3'b001 << (3 - g)));
    if (use_want) check_eq("ready_seq", rdy, want);
    if (g != 2'd0) begin
      case (g)
        2'd1: begin r.sel = gen_reg; r.data = gen_data; end
        2'd2: begin r.sel = lbi_reg; r.data = lbi_imm[7] ? (16'hFF00 | lbi_imm) : {8'h00, lbi_imm}; end
        default: begin r.sel = 3'd7; r.data = 16'((32'(link_pc) + 2) % 65536); end
      endcase
      r.id = g;
      sb.push_back(r);
      m_ptr = g;
    end
    if (was_rst) m_ptr = 2'd3;
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      r = sb.pop_front();
      check_eq("wr_en", wr_en, 1'b1);
      check_eq("wr_sel", wr_sel, r.sel);
      check_eq("wr_data", wr_data, r.data);
      check_eq("grant_id", grant_id, r.id);
      last_sel = r.sel;
      last_data = r.data;
      exp_en = 1'b1;
    end else begin
      if (was_rst) begin
        last_sel = 3'd0;
        last_data = 16'd0;
      end
      check_eq("idle_wr_en", wr_en, 1'b0);
      check_eq("idle_grant_id", grant_id, 2'd0);
      check_eq("hold_wr_sel", wr_sel, last_sel);
      check_eq("hold_wr_data", wr_data, last_data);
      exp_en = 1'b0;
    end
    check_eq("rd1_pending", rd1_pending, exp_en && (last_sel == rd1_sel));
    check_eq("rd2_pending", rd2_pending, exp_en && (last_sel == rd2_sel));
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; wb_stall = 1'b0;
    gen_valid = 1'b0; lbi_valid = 1'b0; link_valid = 1'b0;
    gen_reg = 3'd0; gen_data = 16'd0; lbi_reg = 3'd0; lbi_imm = 8'd0; link_pc = 16'd0;
    rd1_sel = 3'd0; rd2_sel = 3'd1;
    @(negedge clk);
    step(3'b000, 1, g_dummy);
    step(3'b000, 1, g_dummy);
    check_eq("rst_wr_data", wr_data, 16'h0000);
    rst = 1'b0;

    // single gen request
    gen_valid = 1'b1; gen_reg = 3'd3; gen_data = 16'h1234;
    step(3'b100, 1, g_dummy);
    check_eq("gen_data", wr_data, 16'h1234);
    check_eq("gen_sel", wr_sel, 3'd3);

    // pending flags with a write to R4 in flight
    gen_reg = 3'd4; gen_data = 16'h4444; rd1_sel = 3'd4; rd2_sel = 3'd2;
    step(3'b100, 1, g_dummy);
    gen_valid = 1'b0;
    check_eq("rd1_pend_hit", rd1_pending, 1'b1);
    check_eq("rd2_pend_miss", rd2_pending, 1'b0);
    step(3'b000, 1, g_dummy);

    // round robin from reset with all three held valid
    rst = 1'b1;
    step(3'b000, 1, g_dummy);
    rst = 1'b0;
    gen_valid = 1'b1; gen_reg = 3'd1; gen_data = 16'hAAAA;
    lbi_valid = 1'b1; lbi_reg = 3'd5; lbi_imm = 8'h80;
    link_valid = 1'b1; link_pc = 16'hFFFE;
    step(3'b100, 1, g_dummy);
    step(3'b010, 1, g_dummy);
    check_eq("lbi_neg", wr_data, 16'hFF80);
    check_eq("lbi_sel", wr_sel, 3'd5);
    step(3'b001, 1, g_dummy);
    check_eq("link_wrap", wr_data, 16'h0000);
    check_eq("link_sel", wr_sel, 3'd7);
    step(3'b100, 1, g_dummy);
    gen_valid = 1'b0; lbi_valid = 1'b0;
    link_pc = 16'h0100;
    step(3'b001, 1, g_dummy);
    check_eq("link_plus2", wr_data, 16'h0102);
    link_valid = 1'b0;
    lbi_valid = 1'b1; lbi_reg = 3'd2; lbi_imm = 8'h7F;
    step(3'b010, 1, g_dummy);
    check_eq("lbi_pos", wr_data, 16'h007F);
    lbi_valid = 1'b0;

    // stall for two cycles right after a link grant
    link_valid = 1'b1; link_pc = 16'h2000;
    step(3'b001, 1, g_dummy);
    gen_valid = 1'b1; gen_reg = 3'd6; gen_data = 16'hBEEF; wb_stall = 1'b1;
    step(3'b000, 1, g_dummy);
    step(3'b000, 1, g_dummy);
    check_eq("stall_wr_en", wr_en, 1'b0);
    wb_stall = 1'b0;
    step(3'b100, 1, g_dummy);
    gen_valid = 1'b0;
    step(3'b001, 1, g_dummy);
    link_valid = 1'b0;
    step(3'b000, 1, g_dummy);

    // reset while a write sits in the output stage
    gen_valid = 1'b1; gen_reg = 3'd6; gen_data = 16'h5555;
    step(3'b100, 1, g_dummy);
    link_valid = 1'b1; rst = 1'b1;
    step(3'b000, 1, g_dummy);
    check_eq("rst_mid_data", wr_data, 16'h0000);
    rst = 1'b0;
    step(3'b100, 1, g_dummy);
    gen_valid = 1'b0;
    step(3'b001, 1, g_dummy);
    link_valid = 1'b0;
    step(3'b000, 1, g_dummy);

    // random traffic: requesters hold valid and payload until granted
    for (int n = 0; n < 80; n++) begin
      logic [1:0] g;
      if (!gen_valid && $urandom_range(1, 0) == 1) begin
        gen_valid = 1'b1; gen_reg = 3'($urandom); gen_data = 16'($urandom);
      end
      if (!lbi_valid && $urandom_range(1, 0) == 1) begin
        lbi_valid = 1'b1; lbi_reg = 3'($urandom); lbi_imm = 8'($urandom);
      end
      if (!link_valid && $urandom_range(1, 0) == 1) begin
        link_valid = 1'b1; link_pc = 16'($urandom);
      end
      wb_stall = ($urandom_range(3, 0) == 0);
      rd1_sel = 3'($urandom); rd2_sel = 3'($urandom);
      step(3'b000, 0, g);
      if (g == 2'd1) gen_valid = 1'b0;
      if (g == 2'd2) lbi_valid = 1'b0;
      if (g == 2'd3) link_valid = 1'b0;
    end
    gen_valid = 1'b0; lbi_valid = 1'b0; link_valid = 1'b0; wb_stall = 1'b0;
    step(3'b000, 1, g_dummy);
    step(3'b000, 1, g_dummy);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
